// File: rtl/pu_div_master.sv
// Bus initiator for one divider PU: two operand writes, fixed wait, then quotient/remainder reads.
// Optional remainder read is enabled by defining PU_DIV_MASTER_REMAIN_EN.
module pu_div_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ATTR_WIDTH  = 4,
    parameter int INVALID     = 0,
    parameter int WAIT_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_numer,
    input  logic [DATA_WIDTH-1:0] req_denom,
    input  logic [ATTR_WIDTH-1:0] req_attr,
    output logic                  signal_wr,
    output logic                  signal_wr_sel,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  signal_oe,
    output logic                  signal_oe_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_quotient,
    output logic [DATA_WIDTH-1:0] resp_remain,
    output logic                  resp_invalid
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the master never drops resp_valid or changes resp_* before that edge.
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, RD_Q, RD_R, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            cnt;
    logic [DATA_WIDTH-1:0] numer;
    logic [DATA_WIDTH-1:0] denom;
    logic [ATTR_WIDTH-1:0] attr;
    logic                  rst_done;
    logic                  accept;
    logic                  attr_unused;

    assign accept      = req_valid && req_ready;
    assign attr_unused = &{1'b0, attr_in};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            numer         <= '0;
            denom         <= '0;
            attr          <= '0;
            rst_done      <= 1'b0;
            resp_quotient <= '0;
            resp_invalid  <= 1'b0;
        end else begin
            state    <= state_next;
            rst_done <= 1'b1;
            if (accept) begin
                numer <= req_numer;
                denom <= req_denom;
                attr  <= req_attr;
            end
            if (state == WR_B) begin
                cnt <= 8'(WAIT_CYCLES - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
            if (state == RD_Q) begin
                resp_quotient <= data_in;
                resp_invalid  <= attr_in[INVALID];
            end
        end
    end

`ifdef PU_DIV_MASTER_REMAIN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_remain <= '0;
        end else if (state == RD_R) begin
            resp_remain <= data_in;
        end
    end
`else
    assign resp_remain = '0;
`endif

    // Bus outputs are pure state decodes so idle cycles drive zeros onto the wired-OR bus.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        signal_wr     = 1'b0;
        signal_wr_sel = 1'b0;
        data_out      = '0;
        attr_out      = '0;
        signal_oe     = 1'b0;
        signal_oe_sel = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_done;
                if (req_valid && rst_done) state_next = WR_A;
            end
            WR_A: begin
                signal_wr  = 1'b1;
                data_out   = numer;
                attr_out   = attr;
                state_next = WR_B;
            end
            WR_B: begin
                signal_wr     = 1'b1;
                signal_wr_sel = 1'b1;
                data_out      = denom;
                attr_out      = attr;
                state_next    = WAIT;
            end
            WAIT: begin
                if (cnt == 8'd0) state_next = RD_Q;
            end
            RD_Q: begin
                signal_oe = 1'b1;
`ifdef PU_DIV_MASTER_REMAIN_EN
                state_next = RD_R;
`else
                state_next = RESP;
`endif
            end
`ifdef PU_DIV_MASTER_REMAIN_EN
            RD_R: begin
                signal_oe     = 1'b1;
                signal_oe_sel = 1'b1;
                state_next    = RESP;
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pu_div_master.sv
// Bench for pu_div_master: vector table, hold/reset/back-to-back sequences and random jobs
// against a divider PU model and an arithmetic reference.
module tb_pu_div_master;

    localparam int W = 6;
`ifdef PU_DIV_MASTER_REMAIN_EN
    localparam bit REMAIN = 1'b1;
`else
    localparam bit REMAIN = 1'b0;
`endif
    localparam int LAT = REMAIN ? W + 5 : W + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_numer = '0;
    logic [31:0] req_denom = '0;
    logic [3:0]  req_attr = '0;
    logic        signal_wr, signal_wr_sel, signal_oe, signal_oe_sel;
    logic [31:0] data_out, data_in;
    logic [3:0]  attr_out, attr_in;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_quotient, resp_remain;
    logic        resp_invalid;

    pu_div_master #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .INVALID(0), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_numer(req_numer), .req_denom(req_denom), .req_attr(req_attr),
        .signal_wr(signal_wr), .signal_wr_sel(signal_wr_sel),
        .data_out(data_out), .attr_out(attr_out),
        .signal_oe(signal_oe), .signal_oe_sel(signal_oe_sel),
        .data_in(data_in), .attr_in(attr_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_quotient(resp_quotient), .resp_remain(resp_remain), .resp_invalid(resp_invalid)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // divider PU model: latches operands, answers reads combinationally
    logic [31:0] pu_a = '0, pu_b = '0;
    always @(posedge clk) begin
        if (signal_wr) begin
            if (!signal_wr_sel) pu_a <= data_out;
            else pu_b <= data_out;
        end
    end
    always_comb begin
        data_in = 32'hdead_beef;
        attr_in = 4'hf;
        if (signal_oe) begin
            attr_in = {3'b101, pu_b == 32'd0};
            if (pu_b == 32'd0) data_in = signal_oe_sel ? pu_a : 32'hffff_ffff;
            else data_in = signal_oe_sel ? pu_a % pu_b : pu_a / pu_b;
        end
    end

    // bus monitor
    typedef struct { int c; logic sel; logic [31:0] data; logic [3:0] attr; } bus_t;
    bus_t wr_log[$];
    bus_t oe_log[$];
    int   bus_err = 0;
    logic oe_sel_seen = 1'b0;
    always @(negedge clk) begin
        if (signal_wr) wr_log.push_back('{cyc, signal_wr_sel, data_out, attr_out});
        if (signal_oe) oe_log.push_back('{cyc, signal_oe_sel, 32'd0, 4'd0});
        if (!signal_wr && (signal_wr_sel || data_out != 0 || attr_out != 0)) bus_err++;
        if (!signal_oe && signal_oe_sel) bus_err++;
        if (signal_wr && signal_oe) bus_err++;
        if (signal_oe_sel === 1'b1) oe_sel_seen = 1'b1;
    end

    // scoreboard
    int n_vec = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: {quotient, remainder, invalid}
    function automatic logic [64:0] ref_div(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        logic        inv;
        if (d == 0) begin q = 32'hffff_ffff; r = n; inv = 1'b1; end
        else begin q = n / d; r = n % d; inv = 1'b0; end
        if (!REMAIN) r = '0;
        return {q, r, inv};
    endfunction

    task automatic compare_result(input logic [64:0] got);
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("quotient", got[64:33], e[64:33]);
            check("remainder", got[32:1], e[32:1]);
            check("invalid", got[0], e[0]);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("req_ready_idle", req_ready, 1);
    endtask

    task automatic run_job(input logic [31:0] n, input logic [31:0] d, input logic [3:0] a,
                           input logic [64:0] exp, input int hold);
        int k;
        int c1;
        int n_oe;
        logic [64:0] seen;
        wait_ready();
        wr_log.delete();
        oe_log.delete();
        exp_q.push_back(exp);
        req_valid = 1'b1; req_numer = n; req_denom = d; req_attr = a;
        @(negedge clk);
        c1 = cyc;
        req_valid = 1'b0; req_numer = $urandom; req_denom = $urandom; req_attr = 4'($urandom);
        check("req_ready_busy", req_ready, 0);
        k = 1;
        while (resp_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        check("resp_latency", k, LAT);
        check("wr_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("wr_a", {8'(wr_log[0].c - c1 + 1), wr_log[0].sel, wr_log[0].attr, wr_log[0].data},
                  {8'd1, 1'b0, a, n});
            check("wr_b", {8'(wr_log[1].c - c1 + 1), wr_log[1].sel, wr_log[1].attr, wr_log[1].data},
                  {8'd2, 1'b1, a, d});
        end
        n_oe = REMAIN ? 2 : 1;
        check("oe_count", oe_log.size(), n_oe);
        if (oe_log.size() >= 1) check("rd_q", {8'(oe_log[0].c - c1 + 1), oe_log[0].sel}, {8'(W + 3), 1'b0});
        if (oe_log.size() >= 2) check("rd_r", {8'(oe_log[1].c - c1 + 1), oe_log[1].sel}, {8'(W + 4), 1'b1});
        seen = {resp_quotient, resp_remain, resp_invalid};
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_numer = $urandom; req_denom = $urandom;
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_ready", req_ready, 0);
            check("hold_stable", {resp_quotient, resp_remain, resp_invalid}, seen);
        end
        req_valid = 1'b0;
        if (hold > 0) check("hold_no_wr", wr_log.size(), 2);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_valid", resp_valid, 0);
        check("post_ready", req_ready, 1);
        check("post_hold", {resp_quotient, resp_remain, resp_invalid}, seen);
        compare_result(seen);
    endtask

    typedef struct {
        logic [31:0] n, d;
        logic [3:0]  a;
        logic [31:0] q, r;
        logic        inv;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int k;
        int nacc;
        int acc_c[$];
        logic [31:0] n, d;

        vecs[0] = '{32'd100, 32'd7, 4'h3, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{32'd5, 32'd0, 4'h0, 32'hffff_ffff, 32'd5, 1'b1};
        vecs[2] = '{32'd0, 32'd3, 4'h9, 32'd0, 32'd0, 1'b0};
        vecs[3] = '{32'hffff_ffff, 32'd1, 4'hf, 32'hffff_ffff, 32'd0, 1'b0};
        vecs[4] = '{32'd7, 32'd100, 4'h5, 32'd0, 32'd7, 1'b0};
        vecs[5] = '{32'd1234567, 32'd1000, 4'ha, 32'd1234, 32'd567, 1'b0};

        // power-on reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", {signal_wr, signal_wr_sel, data_out, attr_out, signal_oe, signal_oe_sel}, 0);
        check("rst_resp", {resp_valid, resp_quotient, resp_invalid, req_ready}, 0);
        check("rst_remain", resp_remain, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // vector table
        for (int i = 0; i < 6; i++)
            run_job(vecs[i].n, vecs[i].d, vecs[i].a,
                    {vecs[i].q, REMAIN ? vecs[i].r : 32'd0, vecs[i].inv}, 0);

        // consumer stall for 10 cycles
        run_job(32'd100, 32'd7, 4'h1, ref_div(32'd100, 32'd7), 10);

        // random jobs
        for (int i = 0; i < 20; i++) begin
            n = $urandom;
            d = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 70000));
            if ($urandom_range(0, 1) == 1) n = 32'($urandom_range(0, 1000));
            run_job(n, d, 4'($urandom), ref_div(n, d), $urandom_range(0, 3));
        end

        // reset in the middle of WAIT
        wait_ready();
        req_valid = 1'b1; req_numer = 32'd77; req_denom = 32'd5; req_attr = 4'h2;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_bus", {signal_wr, signal_wr_sel, data_out, attr_out, signal_oe, signal_oe_sel}, 0);
        check("midrst_resp", {resp_valid, resp_quotient, resp_invalid, req_ready}, 0);
        check("midrst_remain", resp_remain, 0);
        repeat (2) @(negedge clk);
        check("midrst_ready_low", req_ready, 0);
        rst = 1'b1;
        wr_log.delete();
        oe_log.delete();
        @(negedge clk);
        check("midrst_ready", req_ready, 1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid === 1'b1) k++;
            @(negedge clk);
        end
        check("midrst_no_resp", k, 0);
        check("midrst_no_bus", wr_log.size() + oe_log.size(), 0);

        // back-to-back jobs with req_valid held
        exp_q.push_back(ref_div(32'd100, 32'd7));
        exp_q.push_back(ref_div(32'd9, 32'd4));
        resp_ready = 1'b1;
        req_valid = 1'b1; req_numer = 32'd100; req_denom = 32'd7; req_attr = 4'h0;
        nacc = 0;
        k = 0;
        for (int i = 0; i < 80 && k < 2; i++) begin
            if (nacc == 1) begin req_numer = 32'd9; req_denom = 32'd4; end
            if (nacc == 2) req_valid = 1'b0;
            if (req_valid && req_ready === 1'b1) begin acc_c.push_back(cyc); nacc++; end
            if (resp_valid === 1'b1) begin
                compare_result({resp_quotient, resp_remain, resp_invalid});
                k++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check("b2b_responses", k, 2);
        check("b2b_accepts", acc_c.size(), 2);
        if (acc_c.size() == 2) check("b2b_spacing", acc_c[1] - acc_c[0], LAT + 1);

        check("bus_idle_zero", bus_err, 0);
        check("oe_sel_usage", oe_sel_seen, REMAIN);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
